// File: rtl/rtmq_cfg_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtmq_cfg_uart_tx -- serialises {f_ovr, ins} frames as 8N1/8N2 UART bytes, MSB byte
// first, with an idle gap after each frame. RTMQ_CFG_TX_FIFO_EN: D_FIFO-deep frame FIFO.
// Revision: 1.0
// ----------------------------------------------------------------------------
module rtmq_cfg_uart_tx #(
  parameter int W_REG  = 32,
  parameter int N_STB  = 1,
  parameter int W_BAU  = 8,
  parameter int G_IFG  = 20,
  parameter int D_FIFO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_BAU-1:0] baud,
  input  logic [W_REG-1:0] ins,
  input  logic             f_ovr,
  input  logic             f_snd,
  output logic             f_rdy,
  output logic             f_ovf,
  output logic             f_busy,
  output logic             f_fin,
  output logic             uart_txd
);
  localparam int N_BYT = W_REG / 8 + 1;
  localparam int W_FRM = N_BYT * 8;
  localparam int W_ENT = W_REG + 1;
  localparam int W_BYI = $clog2(N_BYT);
  localparam int W_GAP = $clog2(G_IFG + 1);
  localparam logic [W_BYI-1:0] LAST_BYTE = W_BYI'(N_BYT - 1);
  localparam logic [W_GAP-1:0] LAST_GAP  = W_GAP'(G_IFG - 1);
  localparam logic [1:0]       LAST_STOP = 2'(N_STB - 1);

  if (W_REG % 8 != 0 || N_STB < 1 || N_STB > 2 || G_IFG < 1 || D_FIFO < 1) begin : g_param_check
    $error("rtmq_cfg_uart_tx: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;
  state_t state;

  logic             push, pop, empty, full;
  logic [W_ENT-1:0] head;

  // A full buffer still accepts when the FSM pops in the same cycle.
  assign pop    = (state == S_IDLE) && !empty;
  assign f_rdy  = !full || pop;
  assign push   = f_snd && f_rdy;
  assign f_busy = (state != S_IDLE) || !empty;

`ifdef RTMQ_CFG_TX_FIFO_EN
  localparam int W_PTR = $clog2(D_FIFO);
  logic [W_ENT-1:0] mem [D_FIFO];
  logic [W_PTR:0]   wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[W_PTR] != rd_ptr[W_PTR]) && (wr_ptr[W_PTR-1:0] == rd_ptr[W_PTR-1:0]);
  assign head  = mem[rd_ptr[W_PTR-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[W_PTR-1:0]] <= {f_ovr, ins};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (W_PTR + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (W_PTR + 1)'(1);
    end
  end
`else
  logic             hold_vld;
  logic [W_ENT-1:0] hold_dat;

  assign empty = !hold_vld;
  assign full  = hold_vld;
  assign head  = hold_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (push) begin
      hold_vld <= 1'b1;
      hold_dat <= {f_ovr, ins};
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  logic [W_FRM-1:0] frame;
  logic [7:0]       shreg;
  logic [W_BAU-1:0] bit_len, timer, baud_eff, reload;
  logic [2:0]       bit_idx;
  logic [1:0]       stb_idx;
  logic [W_BYI-1:0] byt_idx;
  logic [W_GAP-1:0] gap_idx;
  logic             bit_end;

  assign baud_eff = (baud < W_BAU'(2)) ? W_BAU'(2) : baud;
  assign reload   = bit_len - W_BAU'(1);
  assign bit_end  = (timer == '0);

  // uart_txd follows the state one cycle later, so every line bit lasts exactly bit_len clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      frame    <= '0;
      shreg    <= '0;
      bit_len  <= '0;
      timer    <= '0;
      bit_idx  <= '0;
      stb_idx  <= '0;
      byt_idx  <= '0;
      gap_idx  <= '0;
      uart_txd <= 1'b1;
      f_fin    <= 1'b0;
      f_ovf    <= 1'b0;
    end else begin
      f_fin <= 1'b0;
      f_ovf <= f_snd && !f_rdy;
      case (state)
        S_START: uart_txd <= 1'b0;
        S_DATA:  uart_txd <= shreg[0];
        default: uart_txd <= 1'b1;
      endcase
      if (state != S_IDLE && !bit_end) timer <= timer - W_BAU'(1);
      case (state)
        S_IDLE: if (pop) begin
          state   <= S_START;
          frame   <= {7'b0, head};
          bit_len <= baud_eff;
          timer   <= baud_eff - W_BAU'(1);
          byt_idx <= '0;
        end
        S_START: if (bit_end) begin
          state   <= S_DATA;
          timer   <= reload;
          shreg   <= frame[W_FRM-1 -: 8];
          frame   <= {frame[W_FRM-9:0], 8'h00};
          bit_idx <= '0;
        end
        S_DATA: if (bit_end) begin
          timer <= reload;
          shreg <= {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state   <= S_STOP;
            stb_idx <= '0;
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        S_STOP: if (bit_end) begin
          timer <= reload;
          if (stb_idx != LAST_STOP) begin
            stb_idx <= stb_idx + 2'd1;
          end else if (byt_idx == LAST_BYTE) begin
            state   <= S_GAP;
            gap_idx <= '0;
            f_fin   <= 1'b1;
          end else begin
            state   <= S_START;
            byt_idx <= byt_idx + W_BYI'(1);
          end
        end
        S_GAP: if (bit_end) begin
          timer <= reload;
          if (gap_idx == LAST_GAP) state <= S_IDLE;
          else                     gap_idx <= gap_idx + W_GAP'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtmq_cfg_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rtmq_cfg_uart_tx -- directed bench: decodes uart_txd and checks frames, timing, flags.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_rtmq_cfg_uart_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  baud = 8'd4;
  logic [31:0] ins = '0;
  logic        f_ovr = 1'b0;
  logic        f_snd = 1'b0;
  logic        f_rdy, f_ovf, f_busy, f_fin, uart_txd;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int fin_cnt = 0;
  int fin_cyc = 0;
  int ovf_cnt = 0;

  logic [39:0] frm, frm2;
  int          t0, t1, dur, dur2, t_s, ti, fin0, ovf0, fin_a;
  logic        ok, ok2, hi, rdy_a, rdy_b, quiet;

  rtmq_cfg_uart_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud     (baud),
    .ins      (ins),
    .f_ovr    (f_ovr),
    .f_snd    (f_snd),
    .f_rdy    (f_rdy),
    .f_ovf    (f_ovf),
    .f_busy   (f_busy),
    .f_fin    (f_fin),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (f_fin) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
    if (f_ovf) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for a start bit, then samples each 5-byte frame bit mid-period.
  task automatic rx_frame(input int bd, output logic [39:0] f, output int ts, output int d,
                          output logic good);
    logic [7:0] byt;
    int n;
    good = 1'b1; f = '0; ts = 0; d = 0; n = 0; byt = '0;
    do begin
      @(negedge clk);
      n++;
    end while (uart_txd !== 1'b0 && n < 3000);
    if (uart_txd !== 1'b0) begin
      good = 1'b0;
      return;
    end
    ts = cyc;
    for (int b = 0; b < 5; b++) begin
      if (b > 0) begin
        repeat (bd - bd / 2) @(negedge clk);
        if (uart_txd !== 1'b0) good = 1'b0;
      end
      repeat (bd / 2) @(negedge clk);
      if (uart_txd !== 1'b0) good = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (bd) @(negedge clk);
        byt[i] = uart_txd;
      end
      repeat (bd) @(negedge clk);
      if (uart_txd !== 1'b1) good = 1'b0;
      f = {f[31:0], byt};
    end
    repeat (bd - bd / 2) @(negedge clk);
    if (uart_txd !== 1'b1) good = 1'b0;
    d = cyc - ts;
  endtask

  task automatic wait_idle(output int t_idle, output logic stayed_high);
    int n;
    n = 0;
    stayed_high = 1'b1;
    while (f_busy === 1'b1 && n < 3000) begin
      if (uart_txd !== 1'b1) stayed_high = 1'b0;
      @(negedge clk);
      n++;
    end
    t_idle = cyc;
  endtask

  task automatic strobe(input logic [31:0] v, input logic o);
    @(negedge clk);
    ins = v; f_ovr = o; f_snd = 1'b1;
    @(negedge clk);
    f_snd = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_txd",  64'(uart_txd), 64'd1);
    check("rst_rdy",  64'(f_rdy),    64'd1);
    check("rst_busy", 64'(f_busy),   64'd0);
    check("rst_ovf",  64'(f_ovf),    64'd0);
    check("rst_fin",  64'(f_fin),    64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // baud 4, ovr 1
    baud = 8'd4; fin0 = fin_cnt;
    @(negedge clk);
    t_s = cyc; ins = 32'hA5C3_0F01; f_ovr = 1'b1; f_snd = 1'b1;
    @(negedge clk);
    f_snd = 1'b0;
    check("busy_after_snd", 64'(f_busy), 64'd1);
    rx_frame(4, frm, t0, dur, ok);
    check("f1_ok",      64'(ok),        64'd1);
    check("f1_data",    64'(frm),       64'h01_A5C3_0F01);
    check("f1_latency", 64'(t0 - t_s),  64'd3);
    check("f1_len",     64'(dur),       64'd200);
    wait_idle(ti, hi);
    check("f1_gap",     64'(ti - fin_cyc),   64'd80);
    check("f1_gap_hi",  64'(hi),             64'd1);
    check("f1_fin_cnt", 64'(fin_cnt - fin0), 64'd1);

    // baud 1 clamps to 2
    baud = 8'd1;
    strobe(32'h1234_5678, 1'b0);
    rx_frame(2, frm, t0, dur, ok);
    check("f2_ok",   64'(ok),  64'd1);
    check("f2_data", 64'(frm), 64'h00_1234_5678);
    check("f2_len",  64'(dur), 64'd100);
    wait_idle(ti, hi);
    check("f2_gap",  64'(ti - fin_cyc), 64'd40);

    baud = 8'd4;
    fin0 = fin_cnt; ovf0 = ovf_cnt;
`ifdef RTMQ_CFG_TX_FIFO_EN
    // six back-to-back strobes into an idle FIFO
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          ins = 32'hC0DE_0000 + 32'(k); f_ovr = k[0]; f_snd = 1'b1;
        end
        @(negedge clk);
        f_snd = 1'b0;
      end
      begin
        fin_a = 0;
        for (int k = 0; k < 5; k++) begin
          rx_frame(4, frm, t0, dur, ok);
          check("fifo_ok",   64'(ok),  64'd1);
          check("fifo_data", 64'(frm), 64'({7'b0, k[0], 32'hC0DE_0000 + 32'(k)}));
          if (k > 0) check("fifo_gap", 64'(t0 - fin_a >= 80), 64'd1);
          fin_a = fin_cyc;
        end
      end
    join
    wait_idle(ti, hi);
    check("fifo_ovf_cnt", 64'(ovf_cnt - ovf0), 64'd1);
    check("fifo_fin_cnt", 64'(fin_cnt - fin0), 64'd5);
`else
    // three strobes during a frame: only the first is held
    strobe(32'hDEAD_BEEF, 1'b0);
    fork
      rx_frame(4, frm, t0, dur, ok);
      begin
        repeat (20) @(negedge clk);
        rdy_a = f_rdy;
        ins = 32'h0000_00FF; f_ovr = 1'b1; f_snd = 1'b1;
        @(negedge clk);
        rdy_b = f_rdy;
        ins = 32'h1111_1111; f_ovr = 1'b0;
        @(negedge clk);
        ins = 32'h2222_2222;
        @(negedge clk);
        f_snd = 1'b0;
      end
    join
    fin_a = fin_cyc;
    check("hold_a_ok",   64'(ok),    64'd1);
    check("hold_a_data", 64'(frm),   64'h00_DEAD_BEEF);
    check("hold_rdy_a",  64'(rdy_a), 64'd1);
    check("hold_rdy_b",  64'(rdy_b), 64'd0);
    rx_frame(4, frm2, t1, dur2, ok2);
    check("hold_b_ok",   64'(ok2),   64'd1);
    check("hold_b_data", 64'(frm2),  64'h01_0000_00FF);
    check("hold_gap",    64'(t1 - fin_a >= 80), 64'd1);
    wait_idle(ti, hi);
    quiet = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) quiet = 1'b0;
    end
    check("hold_no_third", 64'(quiet), 64'd1);
    check("hold_ovf_cnt",  64'(ovf_cnt - ovf0), 64'd2);
    check("hold_fin_cnt",  64'(fin_cnt - fin0), 64'd2);
`endif

    // baud changes mid-frame: current frame keeps 4, next uses 8
    baud = 8'd4;
    strobe(32'h5A5A_0001, 1'b0);
    fork
      rx_frame(4, frm, t0, dur, ok);
      begin
        repeat (20) @(negedge clk);
        baud = 8'd8; ins = 32'h0102_0304; f_ovr = 1'b1; f_snd = 1'b1;
        @(negedge clk);
        f_snd = 1'b0;
      end
    join
    check("bd_a_ok",   64'(ok),  64'd1);
    check("bd_a_data", 64'(frm), 64'h00_5A5A_0001);
    check("bd_a_len",  64'(dur), 64'd200);
    rx_frame(8, frm2, t1, dur2, ok2);
    check("bd_b_ok",   64'(ok2),  64'd1);
    check("bd_b_data", 64'(frm2), 64'h01_0102_0304);
    check("bd_b_len",  64'(dur2), 64'd400);
    wait_idle(ti, hi);
    check("bd_b_gap",  64'(ti - fin_cyc), 64'd160);

    // reset inside byte 2 (all-zero data) returns the line high at once
    baud = 8'd4;
    strobe(32'h00FF_FFFF, 1'b1);
    repeat (52) @(negedge clk);
    check("pre_rst_txd",  64'(uart_txd), 64'd0);
    check("pre_rst_busy", 64'(f_busy),   64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_txd",  64'(uart_txd), 64'd1);
    check("rst_mid_busy", 64'(f_busy),   64'd0);
    check("rst_mid_rdy",  64'(f_rdy),    64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t_s = cyc; ins = 32'h0F0F_0F0F; f_ovr = 1'b0; f_snd = 1'b1;
    @(negedge clk);
    f_snd = 1'b0;
    rx_frame(4, frm, t0, dur, ok);
    check("post_rst_ok",      64'(ok),       64'd1);
    check("post_rst_data",    64'(frm),      64'h00_0F0F_0F0F);
    check("post_rst_latency", 64'(t0 - t_s), 64'd3);
    check("post_rst_len",     64'(dur),      64'd200);
    wait_idle(ti, hi);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
